// File: rtl/ahb_mtx_pkg.sv
// Shared AHB bus-matrix definitions: transfer and burst encodings, arbitration
// policy selectors and the burst-length helper used by the output arbiters.
package ahb_mtx_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Beats remaining after the NONSEQ of a burst; undefined-length bursts give 0.
    function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  burst_beats = 4'd3;
            HBURST_WRAP8,  HBURST_INCR8:  burst_beats = 4'd7;
            HBURST_WRAP16, HBURST_INCR16: burst_beats = 4'd15;
            default:                      burst_beats = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_mtx_arb_param_if.sv
// Request/response bundle between the matrix input stages and one output arbiter.
interface ahb_mtx_arb_param_if #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = $clog2(NUM_PORTS)
);
    logic [NUM_PORTS-1:0] req_port;
    logic                 HREADYM;
    logic                 HSELM;
    logic [1:0]           HTRANSM;
    logic [2:0]           HBURSTM;
    logic                 HMASTLOCKM;
    logic [PORT_W-1:0]    addr_in_port;
    logic                 no_port;
    logic                 burst_hold;

    modport master (
        output req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
        input  addr_in_port, no_port, burst_hold
    );

    modport slave (
        input  req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
        output addr_in_port, no_port, burst_hold
    );
endinterface

// File: rtl/ahb_mtx_rr_pick.sv
// Rotating priority encoder: first set request at or after 'start', wrapping
// modulo NUM_PORTS so non-power-of-two port counts never index past the end.
module ahb_mtx_rr_pick #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_W-1:0]    start,
    output logic [PORT_W-1:0]    winner,
    output logic                 any
);
    logic [PORT_W:0]   sum;
    logic [PORT_W-1:0] idx;

    // Scan from the farthest offset down so the nearest requester is written last.
    always_comb begin
        winner = '0;
        sum    = '0;
        idx    = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            sum = {1'b0, start} + (PORT_W + 1)'(k);
            if (sum >= (PORT_W + 1)'(NUM_PORTS)) begin
                sum = sum - (PORT_W + 1)'(NUM_PORTS);
            end
            idx = sum[PORT_W-1:0];
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/ahb_mtx_arb_param.sv
// Output-stage arbiter for one bus-matrix slave port: fixed or round-robin
// selection with lock hold and burst-aware grant hold for fixed-length bursts.
module ahb_mtx_arb_param #(
    parameter int NUM_PORTS  = 4,
    parameter int PORT_W     = $clog2(NUM_PORTS),
    parameter int ARB_MODE   = 0,
    parameter int BURST_HOLD = 1
) (
    input logic              HCLK,
    input logic              HRESET,
    ahb_mtx_arb_param_if.slave bus
);
    import ahb_mtx_pkg::*;

    logic [PORT_W-1:0]    cur_port;
    logic                 no_port_q;
    logic                 hold_q;
    logic [3:0]           beats_left;
    logic [PORT_W-1:0]    rr_last;

    logic                 trans_active;
    logic                 beat_accept;
    logic                 freeze;
    logic [NUM_PORTS-1:0] eff_req;
    logic [PORT_W-1:0]    rr_start;
    logic [PORT_W-1:0]    pick_port;
    logic                 pick_any;
    logic [PORT_W-1:0]    next_port;
    logic                 next_no;
    logic                 rr_update;
    logic [3:0]           next_beats;

    assign trans_active = (bus.HTRANSM != HTRANS_IDLE);
    assign beat_accept  = bus.HREADYM & bus.HSELM & bus.HTRANSM[1];
    assign freeze       = bus.HMASTLOCKM |
                          ((BURST_HOLD != 0) && (beats_left != 4'd0) && trans_active);

    // The current owner keeps competing while its own transfer is still live.
    assign eff_req = bus.req_port |
                     ((NUM_PORTS'(1) << cur_port) & {NUM_PORTS{bus.HSELM & trans_active}});

    assign rr_start = (ARB_MODE != ARB_RR)                 ? '0 :
                      (rr_last == PORT_W'(NUM_PORTS - 1))  ? '0 :
                                                             rr_last + 1'b1;

    ahb_mtx_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_W    (PORT_W)
    ) u_pick (
        .req    (eff_req),
        .start  (rr_start),
        .winner (pick_port),
        .any    (pick_any)
    );

    always_comb begin
        next_port = cur_port;
        next_no   = no_port_q;
        rr_update = 1'b0;
        if (!freeze) begin
            if (pick_any) begin
                next_port = pick_port;
                next_no   = 1'b0;
                // A grant out of the no-port state counts as a new owner.
                rr_update = (pick_port != cur_port) || no_port_q ||
                            (bus.HSELM && bus.HTRANSM == HTRANS_NONSEQ);
            end else begin
                next_no = ~bus.HSELM;
            end
        end
    end

    always_comb begin
        next_beats = beats_left;
        if (beat_accept && bus.HTRANSM == HTRANS_NONSEQ) begin
            next_beats = burst_beats(bus.HBURSTM);
        end else if (beat_accept) begin
            next_beats = (beats_left == 4'd0) ? 4'd0 : beats_left - 4'd1;
        end else if (bus.HTRANSM == HTRANS_IDLE) begin
            next_beats = 4'd0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            cur_port   <= '0;
            no_port_q  <= 1'b1;
            hold_q     <= 1'b0;
            beats_left <= 4'd0;
            rr_last    <= PORT_W'(NUM_PORTS - 1);
        end else if (bus.HREADYM) begin
            cur_port   <= next_port;
            no_port_q  <= next_no;
            hold_q     <= (next_beats != 4'd0);
            beats_left <= next_beats;
            if (rr_update) begin
                rr_last <= next_port;
            end
        end
    end

    assign bus.addr_in_port = cur_port;
    assign bus.no_port      = no_port_q;
    assign bus.burst_hold   = hold_q;

endmodule

// File: tb/tb_ahb_mtx_arb_param.sv
// Bench for ahb_mtx_arb_param: a 4-port fixed-priority and a 5-port round-robin
// instance share one stimulus stream and are checked against a behavioural model.
`timescale 1ns/1ps
module tb_ahb_mtx_arb_param;
    import ahb_mtx_pkg::*;

    typedef struct {
        logic [4:0] req;
        logic       rdy;
        logic       sel;
        logic [1:0] trans;
        logic [2:0] burst;
        logic       lock;
        logic       rst;
        int         target;
        int         exp_port;
        logic       exp_no;
        logic       exp_hold;
    } vec_t;

    logic       HCLK = 1'b0;
    logic       HRESET;
    logic [4:0] req;
    logic       rdy, sel, lock;
    logic [1:0] trans;
    logic [2:0] burst;

    int nChecks = 0;
    int nFails  = 0;

    int m_port [2];
    int m_no   [2];
    int m_beats[2];
    int m_last [2];
    int lens   [8] = '{1, 1, 4, 4, 8, 8, 16, 16};

    vec_t tbl[$];

    always #5 HCLK = ~HCLK;

    ahb_mtx_arb_param_if #(.NUM_PORTS(4)) fix_if ();
    ahb_mtx_arb_param_if #(.NUM_PORTS(5)) rr_if ();

    assign fix_if.req_port   = req[3:0];
    assign fix_if.HREADYM    = rdy;
    assign fix_if.HSELM      = sel;
    assign fix_if.HTRANSM    = trans;
    assign fix_if.HBURSTM    = burst;
    assign fix_if.HMASTLOCKM = lock;
    assign rr_if.req_port    = req;
    assign rr_if.HREADYM     = rdy;
    assign rr_if.HSELM       = sel;
    assign rr_if.HTRANSM     = trans;
    assign rr_if.HBURSTM     = burst;
    assign rr_if.HMASTLOCKM  = lock;

    ahb_mtx_arb_param #(.NUM_PORTS(4), .ARB_MODE(ARB_FIXED), .BURST_HOLD(1)) dut_fix (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (fix_if.slave)
    );

    ahb_mtx_arb_param #(.NUM_PORTS(5), .ARB_MODE(ARB_RR), .BURST_HOLD(1)) dut_rr (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (rr_if.slave)
    );

    function automatic vec_t mkv(input logic [4:0] r, input logic rd, input logic s,
                                 input logic [1:0] t, input logic [2:0] b, input logic l,
                                 input logic rs, input int tg, input int ep,
                                 input logic en, input logic eh);
        vec_t v;
        v.req = r; v.rdy = rd; v.sel = s; v.trans = t; v.burst = b; v.lock = l;
        v.rst = rs; v.target = tg; v.exp_port = ep; v.exp_no = en; v.exp_hold = eh;
        return v;
    endfunction

    // Arbitration rules stated directly: lock, then burst hold, then a search
    // over the effective requests, then HSELM decides between keep and no-port.
    task automatic modelStep(input int d, input vec_t v);
        int n;
        int win;
        logic [4:0] eff;
        bit active;
        n = (d == 0) ? 4 : 5;
        if (v.rst) begin
            m_port[d] = 0; m_no[d] = 1; m_beats[d] = 0; m_last[d] = n - 1;
            return;
        end
        if (!v.rdy) return;
        active = (v.trans != 2'b00);
        eff = v.req & 5'((1 << n) - 1);
        if (v.sel && active) eff[m_port[d]] = 1'b1;
        if (!v.lock && !(m_beats[d] > 0 && active)) begin
            win = -1;
            for (int k = 0; k < n; k++) begin
                int idx;
                idx = (d == 0) ? k : (m_last[d] + 1 + k) % n;
                if (win < 0 && eff[idx]) win = idx;
            end
            if (win >= 0) begin
                if (win != m_port[d] || m_no[d] != 0 || (v.sel && v.trans == 2'b10))
                    m_last[d] = win;
                m_port[d] = win;
                m_no[d]   = 0;
            end else begin
                m_no[d] = v.sel ? 0 : 1;
            end
        end
        if (v.sel && v.trans == 2'b10)      m_beats[d] = lens[v.burst] - 1;
        else if (v.sel && v.trans == 2'b11) m_beats[d] = (m_beats[d] > 0) ? m_beats[d] - 1 : 0;
        else if (v.trans == 2'b00)          m_beats[d] = 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        req = v.req; rdy = v.rdy; sel = v.sel; trans = v.trans;
        burst = v.burst; lock = v.lock; HRESET = v.rst;
        @(posedge HCLK);
        modelStep(0, v);
        modelStep(1, v);
        #1;
    endtask

    task automatic checkOutput(input string name, input vec_t v);
        check({name, " fix.port"}, 32'(fix_if.addr_in_port), 32'(m_port[0]));
        check({name, " fix.no"},   32'(fix_if.no_port),      32'(m_no[0]));
        check({name, " fix.hold"}, 32'(fix_if.burst_hold),   32'(m_beats[0] != 0));
        check({name, " rr.port"},  32'(rr_if.addr_in_port),  32'(m_port[1]));
        check({name, " rr.no"},    32'(rr_if.no_port),       32'(m_no[1]));
        check({name, " rr.hold"},  32'(rr_if.burst_hold),    32'(m_beats[1] != 0));
        if (v.target == 0) begin
            check({name, " fix.port.const"}, 32'(fix_if.addr_in_port), 32'(v.exp_port));
            check({name, " fix.no.const"},   32'(fix_if.no_port),      32'(v.exp_no));
            check({name, " fix.hold.const"}, 32'(fix_if.burst_hold),   32'(v.exp_hold));
        end else if (v.target == 1) begin
            check({name, " rr.port.const"},  32'(rr_if.addr_in_port),  32'(v.exp_port));
            check({name, " rr.no.const"},    32'(rr_if.no_port),       32'(v.exp_no));
            check({name, " rr.hold.const"},  32'(rr_if.burst_hold),    32'(v.exp_hold));
        end
    endtask

    task automatic runVec(input string name, input vec_t v);
        applyStimulus(v);
        checkOutput(name, v);
    endtask

    task automatic doReset();
        runVec("reset", mkv(5'b0, 1, 0, HTRANS_IDLE, HBURST_SINGLE, 0, 1, 0, 0, 1, 0));
        runVec("reset", mkv(5'b0, 1, 0, HTRANS_IDLE, HBURST_SINGLE, 0, 1, 0, 0, 1, 0));
    endtask

    task automatic grantPort2();
        runVec("grant2", mkv(5'b00100, 1, 0, HTRANS_IDLE, HBURST_SINGLE, 0, 0, 0, 2, 0, 0));
    endtask

    initial begin
        vec_t v;

        tbl.push_back(mkv(5'b00000, 1, 0, HTRANS_IDLE,   HBURST_SINGLE, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mkv(5'b00000, 1, 0, HTRANS_IDLE,   HBURST_SINGLE, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mkv(5'b00000, 1, 0, HTRANS_IDLE,   HBURST_SINGLE, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mkv(5'b01010, 1, 0, HTRANS_IDLE,   HBURST_SINGLE, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mkv(5'b01000, 1, 1, HTRANS_NONSEQ, HBURST_SINGLE, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mkv(5'b01000, 1, 0, HTRANS_IDLE,   HBURST_SINGLE, 0, 0, 0, 3, 0, 0));
        tbl.push_back(mkv(5'b00001, 0, 0, HTRANS_IDLE,   HBURST_SINGLE, 0, 0, 0, 3, 0, 0));
        tbl.push_back(mkv(5'b00000, 1, 0, HTRANS_IDLE,   HBURST_SINGLE, 0, 0, 0, 3, 1, 0));
        tbl.push_back(mkv(5'b00000, 1, 1, HTRANS_IDLE,   HBURST_SINGLE, 0, 0, 0, 3, 0, 0));
        tbl.push_back(mkv(5'b10000, 1, 0, HTRANS_IDLE,   HBURST_SINGLE, 0, 0, 0, 3, 1, 0));
        for (int i = 0; i < tbl.size(); i++) begin
            runVec($sformatf("table[%0d]", i), tbl[i]);
        end

        // Round-robin rotation across ports 0..3 of the 5-port instance.
        doReset();
        for (int i = 0; i < 5; i++) begin
            runVec($sformatf("rr[%0d]", i),
                   mkv(5'b01111, 1, 1, HTRANS_NONSEQ, HBURST_SINGLE, 0, 0, 1, i % 4, 0, 0));
        end

        // INCR8 by port 2 with a BUSY beat and wait states, port 0 waiting.
        doReset();
        grantPort2();
        runVec("burst nonseq", mkv(5'b00100, 1, 1, HTRANS_NONSEQ, HBURST_INCR8, 0, 0, 0, 2, 0, 1));
        for (int i = 0; i < 3; i++)
            runVec("burst seq", mkv(5'b00101, 1, 1, HTRANS_SEQ, HBURST_INCR8, 0, 0, 0, 2, 0, 1));
        runVec("burst busy", mkv(5'b00101, 1, 1, HTRANS_BUSY, HBURST_INCR8, 0, 0, 0, 2, 0, 1));
        for (int i = 0; i < 2; i++)
            runVec("burst wait", mkv(5'b00101, 0, 1, HTRANS_SEQ, HBURST_INCR8, 0, 0, 0, 2, 0, 1));
        for (int i = 0; i < 3; i++)
            runVec("burst seq", mkv(5'b00101, 1, 1, HTRANS_SEQ, HBURST_INCR8, 0, 0, 0, 2, 0, 1));
        runVec("burst last", mkv(5'b00101, 1, 1, HTRANS_SEQ, HBURST_INCR8, 0, 0, 0, 2, 0, 0));
        runVec("burst after", mkv(5'b00001, 1, 0, HTRANS_IDLE, HBURST_SINGLE, 0, 0, 0, 0, 0, 0));

        // WRAP16 cut short by IDLE after five beats.
        doReset();
        grantPort2();
        runVec("early nonseq", mkv(5'b00100, 1, 1, HTRANS_NONSEQ, HBURST_WRAP16, 0, 0, 0, 2, 0, 1));
        for (int i = 0; i < 4; i++)
            runVec("early seq", mkv(5'b00101, 1, 1, HTRANS_SEQ, HBURST_WRAP16, 0, 0, 0, 2, 0, 1));
        runVec("early idle", mkv(5'b00001, 1, 1, HTRANS_IDLE, HBURST_WRAP16, 0, 0, 0, 0, 0, 0));

        // Same cut-short burst under lock: the grant stays until the lock drops.
        doReset();
        grantPort2();
        runVec("lock nonseq", mkv(5'b00100, 1, 1, HTRANS_NONSEQ, HBURST_WRAP16, 1, 0, 0, 2, 0, 1));
        for (int i = 0; i < 4; i++)
            runVec("lock seq", mkv(5'b00101, 1, 1, HTRANS_SEQ, HBURST_WRAP16, 1, 0, 0, 2, 0, 1));
        runVec("lock idle", mkv(5'b00001, 1, 1, HTRANS_IDLE, HBURST_WRAP16, 1, 0, 0, 2, 0, 0));
        runVec("lock drop", mkv(5'b00001, 1, 1, HTRANS_IDLE, HBURST_WRAP16, 0, 0, 0, 0, 0, 0));

        // Reset during a wait state in the middle of an INCR16.
        doReset();
        grantPort2();
        runVec("rst nonseq", mkv(5'b00100, 1, 1, HTRANS_NONSEQ, HBURST_INCR16, 0, 0, 0, 2, 0, 1));
        runVec("rst seq",    mkv(5'b00101, 1, 1, HTRANS_SEQ,    HBURST_INCR16, 0, 0, 0, 2, 0, 1));
        runVec("rst mid",    mkv(5'b00101, 0, 1, HTRANS_SEQ,    HBURST_INCR16, 0, 1, 0, 0, 1, 0));
        runVec("rst after",  mkv(5'b00000, 1, 0, HTRANS_IDLE,   HBURST_SINGLE, 0, 0, 0, 0, 1, 0));

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            v = mkv(5'($urandom), ($urandom % 4) != 0, 1'($urandom), 2'($urandom),
                    3'($urandom), ($urandom % 8) == 0, ($urandom % 64) == 0, -1, 0, 0, 0);
            runVec($sformatf("rand[%0d]", i), v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/ahb_mtx_arb_param.md
# ahb_mtx_arb_param

Parametrised output-stage arbiter for the AHB bus matrix: selects which of NUM_PORTS input stages drives the shared slave port. Generalises the fixed-priority, sparse output arbiters to a dense request vector with selectable fixed-priority or round-robin policy. Adds burst-aware grant hold so fixed-length bursts are never split, and keeps the existing lock and IDLE-hold behaviour. One instance sits per matrix output port, between the input stages' request lines and the output-stage address mux.

## Interface
- NUM_PORTS, 4, number of input ports requesting this output; 2..16
- PORT_W, $clog2(NUM_PORTS), width of the port index
- ARB_MODE, 0, 0 = fixed priority (port 0 highest), 1 = round-robin
- BURST_HOLD, 1, 1 = hold the grant for the full length of fixed-length bursts, 0 = re-arbitrate on every beat
- HCLK  in  1  AHB clock
- HRESET  in  1  synchronous active-high reset
- req_port  in  NUM_PORTS  per-port request, bit i = input port i
- HREADYM  in  1  transfer done on the output port
- HSELM  in  1  slave select of the currently granted stage
- HTRANSM  in  2  transfer type of the currently granted stage
- HBURSTM  in  3  burst type of the currently granted stage
- HMASTLOCKM  in  1  locked transfer
- addr_in_port  out  PORT_W  granted port index (registered)
- no_port  out  1  no port selected (registered)
- burst_hold  out  1  grant is frozen by the burst counter (registered)

## Operation
- All state updates only on HCLK cycles with HREADYM=1. With HREADYM=0, all state holds.
- Beat acceptance: HREADYM & HSELM & HTRANSM[1]=1 (NONSEQ or SEQ).
- Priority of decisions, first match wins:
  1. HMASTLOCKM=1: keep the current port and the current no_port.
  2. BURST_HOLD=1 and beats_left≠0 and HTRANSM≠IDLE: keep the current port.
  3. Arbitrate over eff_req = req_port | (onehot(cur) & {HSELM & HTRANSM≠IDLE}).
     - Fixed mode: pick the lowest set index.
     - Round-robin mode: pick the first set index starting at last+1, wrapping modulo NUM_PORTS; `last` is updated to the winner only when the winner differs from cur, or when cur starts a new NONSEQ.
  4. eff_req=0 and HSELM=1: keep the current port, no_port=0.
  5. Otherwise: no_port=1, addr_in_port unchanged.
- Burst counter `beats_left` (4 bits):
  - Accepted NONSEQ with INCR4/WRAP4 loads 3; with INCR8/WRAP8 loads 7; with INCR16/WRAP16 loads 15; with SINGLE or INCR loads 0.
  - Accepted SEQ decrements the counter, saturating at 0.
  - BUSY leaves it unchanged.
  - IDLE clears it, which is early burst termination.
  - A NONSEQ reloads it per the rules above.
- burst_hold = (beats_left≠0) after the update.
- Reset values: addr_in_port=0, no_port=1, burst_hold=0, beats_left=0, rr last=NUM_PORTS-1, so port 0 wins first.

## Timing
- Decision is combinational from inputs. Outputs are registered and change on the HCLK edge where HREADYM=1, giving 1-cycle latency from the request to addr_in_port.
- Reset is synchronous: HRESET sampled high forces the reset values on that edge regardless of HREADYM. Reset mid-burst or mid-lock discards the hold.
- Lock and burst hold active together: lock dominates, and the counter still tracks beats.
- Counter reaching 0 on the last SEQ: re-arbitration applies to the same edge's decision for the next address phase. The last beat's address phase holds; the decision after it is free.
- req_port bits for ports ≥ NUM_PORTS do not exist. NUM_PORTS not a power of two: the RR wrap uses modulo NUM_PORTS, never an out-of-range index.

## Structure
- Shared package ahb_mtx_pkg:
  - HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ)
  - HBURST encodings
  - ARB_FIXED/ARB_RR constants
  - function burst_beats(hburst) returning length-1
- Sub-module ahb_mtx_rr_pick: rotating priority encoder (req vector, start index → winner index, any).
  - Fixed mode instantiates it with start=0.

## Test plan
- Reset with HRESET=1 for 2 cycles, then req_port=0, HSELM=0 → addr_in_port=0, no_port=1, burst_hold=0.
- Fixed mode, NUM_PORTS=4: req_port=4'b1010 with HREADYM=1 → next edge addr_in_port=1; then req_port=4'b1000 with port 1 still active non-IDLE → stays 1; port 1 goes IDLE with HSELM=0 → addr_in_port=3.
- Round-robin mode: all four requesting continuously with single NONSEQ transfers → grants 0,1,2,3,0 on successive accepted edges.
- Burst hold: port 2 issues NONSEQ INCR8 while port 0 requests → port 2 holds for 8 accepted beats with burst_hold=1, including through a BUSY beat and HREADYM=0 wait states; port 0 is granted on the edge after the 8th beat.
- Early termination: WRAP16 broken by IDLE after 5 beats → beats_left=0 and port 0 granted on that edge. Repeat with HMASTLOCKM=1 → port 2 held until lock drops.
- Synchronous reset asserted mid-INCR16 while HREADYM=0 → next edge no_port=1, addr_in_port=0, burst_hold=0.
